// File: rtl/ps2_key_tracker.sv
// PS/2 Set-2 scancode sequencer: prefix FSM -> held keys, paddle directions, edge pulses.
// Latency 1 (outputs registered at the strobe edge); no backpressure, one byte per cycle accepted.
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 1_300_000,
  parameter int TO_WIDTH       = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] code_byte,
  input  logic       code_valid,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p2_up,
  output logic       p2_down,
  output logic       start_pulse,
  output logic       esc_pulse,
  output logic       pause_pulse
);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  typedef struct packed {
    logic w;
    logic s;
    logic up;
    logic dn;
    logic space;
    logic esc;
  } held_t;

  localparam logic [TO_WIDTH-1:0] TO_MAX = TO_WIDTH'(TIMEOUT_CYCLES);

  state_t              state_q, state_d;
  held_t               held_q, held_d;
  logic [2:0]          skip_q, skip_d;
  logic [TO_WIDTH-1:0] to_cnt_q;
  logic                start_d, esc_d, pause_d;
  logic                to_expire;

  assign to_expire = (state_q != IDLE) && (to_cnt_q == TO_MAX);

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    skip_d  = skip_q;
    start_d = 1'b0;
    esc_d   = 1'b0;
    pause_d = 1'b0;
    if (code_valid) begin
      case (state_q)
        IDLE: begin
          case (code_byte)
            8'hE0: state_d = EXT;
            8'hF0: state_d = BRK;
            8'hE1: begin
              state_d = PAUSE;
              skip_d  = 3'd7;
            end
            8'h1D: held_d.w = 1'b1;
            8'h1B: held_d.s = 1'b1;
            8'h29: begin
              held_d.space = 1'b1;
              start_d      = ~held_q.space;
            end
            8'h76: begin
              held_d.esc = 1'b1;
              esc_d      = ~held_q.esc;
            end
            default: ;
          endcase
        end
        EXT: begin
          state_d = IDLE;
          case (code_byte)
            8'hF0: state_d = EXT_BRK;
            8'h75: held_d.up = 1'b1;
            8'h72: held_d.dn = 1'b1;
            default: ;
          endcase
        end
        BRK: begin
          state_d = IDLE;
          case (code_byte)
            8'h1D: held_d.w     = 1'b0;
            8'h1B: held_d.s     = 1'b0;
            8'h29: held_d.space = 1'b0;
            8'h76: held_d.esc   = 1'b0;
            default: ;
          endcase
        end
        EXT_BRK: begin
          state_d = IDLE;
          case (code_byte)
            8'h75: held_d.up = 1'b0;
            8'h72: held_d.dn = 1'b0;
            default: ;
          endcase
        end
        PAUSE: begin
          // Pause bytes are counted, not decoded; the last one fires the pulse.
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            pause_d = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (to_expire) begin
      state_d = IDLE;
      skip_d  = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      held_q   <= '0;
      skip_q   <= 3'd0;
      to_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      skip_q  <= skip_d;
      if (code_valid || state_q == IDLE || to_expire) to_cnt_q <= '0;
      else                                            to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // Outputs derive from next-state held bits so they appear right after the strobe edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_up       <= 1'b0;
      p1_down     <= 1'b0;
      p2_up       <= 1'b0;
      p2_down     <= 1'b0;
      start_pulse <= 1'b0;
      esc_pulse   <= 1'b0;
      pause_pulse <= 1'b0;
    end else begin
      p1_up       <= held_d.w & ~held_d.s;
      p1_down     <= held_d.s & ~held_d.w;
      p2_up       <= held_d.up & ~held_d.dn;
      p2_down     <= held_d.dn & ~held_d.up;
      start_pulse <= start_d;
      esc_pulse   <= esc_d;
      pause_pulse <= pause_d;
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: byte vectors with hand-computed outputs plus timeout/reset sequences.
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] code_byte = 8'h00;
  logic       code_valid = 1'b0;
  logic       p1_up, p1_down, p2_up, p2_down, start_pulse, esc_pulse, pause_pulse;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ps2_key_tracker #(.TIMEOUT_CYCLES(50), .TO_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .code_byte(code_byte), .code_valid(code_valid),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .start_pulse(start_pulse), .esc_pulse(esc_pulse), .pause_pulse(pause_pulse)
  );

  // Output order: {p1_up, p1_down, p2_up, p2_down, start, esc, pause}
  typedef struct {
    string      name;
    logic       vld;
    logic [7:0] b;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic vld, input logic [7:0] b, input logic [6:0] exp);
    vec_t v;
    v.name = name; v.vld = vld; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {p1_up, p1_down, p2_up, p2_down, start_pulse, esc_pulse, pause_pulse};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle (strobe or idle) and sample just after the edge.
  task automatic step(input logic vld, input logic [7:0] b);
    @(negedge clk);
    code_valid = vld;
    code_byte  = b;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
  endtask

  initial begin
    // W make / break, S untouched
    add("w_make",    1, 8'h1D, 7'b1000000);
    add("w_brk_f0",  1, 8'hF0, 7'b1000000);
    add("w_brk",     1, 8'h1D, 7'b0000000);
    // Arrow keys with conflict resolution
    add("up_e0",     1, 8'hE0, 7'b0000000);
    add("up_make",   1, 8'h75, 7'b0010000);
    add("dn_e0",     1, 8'hE0, 7'b0010000);
    add("dn_make",   1, 8'h72, 7'b0000000);
    add("upb_e0",    1, 8'hE0, 7'b0000000);
    add("upb_f0",    1, 8'hF0, 7'b0000000);
    add("up_brk",    1, 8'h75, 7'b0001000);
    add("dnb_e0",    1, 8'hE0, 7'b0001000);
    add("dnb_f0",    1, 8'hF0, 7'b0001000);
    add("dn_brk",    1, 8'h72, 7'b0000000);
    // Space typematic: pulse only on first make
    add("sp_make1",  1, 8'h29, 7'b0000100);
    add("sp_gap",    0, 8'h00, 7'b0000000);
    for (int i = 0; i < 4; i++) add("sp_rep", 1, 8'h29, 7'b0000000);
    add("sp_f0",     1, 8'hF0, 7'b0000000);
    add("sp_brk",    1, 8'h29, 7'b0000000);
    add("sp_make2",  1, 8'h29, 7'b0000100);
    add("sp_gap2",   0, 8'h00, 7'b0000000);
    // Esc pulse and repeat
    add("esc_make",  1, 8'h76, 7'b0000010);
    add("esc_rep",   1, 8'h76, 7'b0000000);
    add("esc_f0",    1, 8'hF0, 7'b0000000);
    add("esc_brk",   1, 8'h76, 7'b0000000);
    // Pause sequence (space still held, must not pulse again afterwards)
    add("ps_1",      1, 8'hE1, 7'b0000000);
    add("ps_2",      1, 8'h14, 7'b0000000);
    add("ps_3",      1, 8'h77, 7'b0000000);
    add("ps_4",      1, 8'hE1, 7'b0000000);
    add("ps_5",      1, 8'hF0, 7'b0000000);
    add("ps_6",      1, 8'h14, 7'b0000000);
    add("ps_7",      1, 8'hF0, 7'b0000000);
    add("ps_8",      1, 8'h77, 7'b0000001);
    add("ps_gap",    0, 8'h00, 7'b0000000);
    add("s_make",    1, 8'h1B, 7'b0100000);
    add("sp_held",   1, 8'h29, 7'b0100000);
    // W/S conflict and duplicate events
    add("w_make2",   1, 8'h1D, 7'b0000000);
    add("s_f0",      1, 8'hF0, 7'b0000000);
    add("s_brk",     1, 8'h1B, 7'b1000000);
    add("s_f0_dup",  1, 8'hF0, 7'b1000000);
    add("s_brk_dup", 1, 8'h1B, 7'b1000000);
    add("w_dup",     1, 8'h1D, 7'b1000000);
    // Fake shift E0 12 is ignored
    add("fs_e0",     1, 8'hE0, 7'b1000000);
    add("fs_12",     1, 8'h12, 7'b1000000);
    add("w_f0",      1, 8'hF0, 7'b1000000);
    add("w_brk2",    1, 8'h1D, 7'b0000000);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 7'b0000000);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 8'h00);
    check("post_reset", 7'b0000000);

    foreach (vecs[i]) begin
      step(vecs[i].vld, vecs[i].b);
      check(vecs[i].name, vecs[i].exp);
    end

    // Stalled E0 times out; 72 then decodes as an unknown plain make.
    step(1, 8'hE0);
    repeat (55) step(0, 8'h00);
    check("to_idle", 7'b0000000);
    step(1, 8'h72);
    check("to_72_plain", 7'b0000000);
    step(1, 8'h1D);
    check("to_back_idle", 7'b1000000);

    // Reset in the middle of a break sequence.
    step(1, 8'hF0);
    check("rst_pre", 7'b1000000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_async", 7'b0000000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", 7'b0000000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 8'h1D);
    check("rst_then_make", 7'b1000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
